fifo_tx_drain_module: RTL and testbench
=======================================

Name: fifo_tx_drain_module

Overview:
- Transmit-side consumer of the TX FIFO: whenever the FIFO is non-empty, pops one byte and serializes it onto the UART TX pin as an 8N1 frame, or 8E1/8O1 when parity is enabled.
- Sits between the TX FIFO, which is filled by the inter-control loopback logic, and the board TX pin.
- Contains its own baud counter, so no separate bps module is needed.

Parameters:
- BPS_CNT, 434: clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- PARITY_EN, 0: 1 inserts a parity bit between D7 and the stop bit.
- PARITY_ODD, 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd.

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  asynchronous active-low reset.
- TX_En_Sig  input  1  transmit enable; sampled only in IDLE.
- Empty_Sig  input  1  TX FIFO empty flag.
- FIFO_Read_Data  input  8  TX FIFO read data; valid the cycle after a read request.
- Read_Req_Sig  output  1  one-cycle FIFO pop request, registered.
- TX_Pin_Out  output  1  serial line; idles high.
- TX_Busy_Sig  output  1  high from the pop request through the end of the stop bit.

Behaviour:
- Reset is asynchronous and immediate, including mid-frame:
  - TX_Pin_Out=1, Read_Req_Sig=0, TX_Busy_Sig=0.
  - State=IDLE, baud counter=0, bit index=0, shift register=0.
  - The partially sent byte is discarded and is not re-popped.
- All outputs are registered.
- States: IDLE, REQ, WAIT, LATCH, START, DATA, PARITY, STOP.
- IDLE:
  - TX_Pin_Out=1, TX_Busy_Sig=0.
  - If TX_En_Sig=1 and Empty_Sig=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ: Read_Req_Sig=1 for exactly this cycle, TX_Busy_Sig=1, go to WAIT.
- WAIT: Read_Req_Sig=0. The FIFO presents data during this cycle. Go to LATCH.
- LATCH:
  - Capture FIFO_Read_Data into the shift register.
  - Compute parity = XOR of the 8 bits, XOR PARITY_ODD.
  - Go to START.
- START: TX_Pin_Out=0 for BPS_CNT cycles.
- DATA:
  - Bits are sent LSB first, each held BPS_CNT cycles.
  - The bit index counts 0..7; after bit 7 go to PARITY if PARITY_EN=1, else STOP.
- PARITY: TX_Pin_Out=parity bit for BPS_CNT cycles.
- STOP:
  - TX_Pin_Out=1 for BPS_CNT cycles, then go to IDLE.
  - TX_Busy_Sig drops on entry to IDLE.
- Baud counter:
  - 16-bit, cleared on every bit entry.
  - Counts 0..BPS_CNT-1; the bit ends when the count reaches BPS_CNT-1.
- Frame length on the pin: (10 + PARITY_EN) × BPS_CNT cycles.
- Timing between back-to-back bytes:
  - Pop request to first start-bit cycle: 3 cycles (REQ, WAIT, LATCH).
  - End of stop bit to next Read_Req_Sig: 1 cycle (IDLE).
  - Idle-high gap seen on the pin between frames: 4 cycles beyond the stop bit.
- Empty_Sig and TX_En_Sig are ignored outside IDLE:
  - Deasserting TX_En_Sig mid-frame finishes the current frame and then holds in IDLE.
  - The FIFO going empty mid-frame has no effect.
- Read_Req_Sig is never asserted while Empty_Sig=1 in the cycle of the IDLE decision.
- Reads per byte:
  - Exactly one pop per transmitted byte.
  - No pop is issued while TX_Busy_Sig is already high from an earlier request.

Test Plan:
- BPS_CNT=4, PARITY_EN=0, FIFO preloaded with 0x55, TX_En_Sig=1:
  - One 1-cycle Read_Req_Sig.
  - Pin low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - TX_Busy_Sig high for 43 cycles.
- FIFO holds 0xA3 and 0x0F:
  - Two pops.
  - Second Read_Req_Sig exactly 1 cycle after the first stop bit ends.
  - Decoded bytes are 0xA3 then 0x0F.
  - No third pop once Empty_Sig=1.
- PARITY_EN=1:
  - PARITY_ODD=0 with 0x07 gives parity bit 1, 11-bit frame of 44 cycles.
  - PARITY_ODD=1 with 0x07 gives parity bit 0.
- TX_En_Sig=0 with a non-empty FIFO: no Read_Req_Sig and pin stays 1. Raising TX_En_Sig gives Read_Req_Sig on the next cycle.
- RSTn pulsed low during DATA bit 3:
  - Pin goes to 1 asynchronously, TX_Busy_Sig=0.
  - After release, with Empty_Sig=0, the next byte pops and is sent as a full frame.
- Clear TX_En_Sig during the START bit: the frame completes intact, then no further pops.

Source files
------------

// File: rtl/fifo_tx_drain_module.sv
// fifo_tx_drain_module
// Pops one byte at a time from the TX FIFO and shifts it out on the UART TX pin.
// The frame is 8N1, or 8E1/8O1 when parity is enabled.
// The module carries its own baud counter.
// Every output is a flop whose value is derived from the next state,
// so each output lines up exactly with the state it belongs to.
module fifo_tx_drain_module #(
    parameter int unsigned BPS_CNT    = 434,   // clock cycles per bit, 2..65535
    parameter bit          PARITY_EN  = 1'b0,  // insert a parity bit after D7
    parameter bit          PARITY_ODD = 1'b0   // 0: even parity, 1: odd parity
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       TX_En_Sig,
    input  logic       Empty_Sig,
    input  logic [7:0] FIFO_Read_Data,
    output logic       Read_Req_Sig,
    output logic       TX_Pin_Out,
    output logic       TX_Busy_Sig
);

    // Last count value of a bit period; the bit ends when the counter reaches it.
    localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LATCH,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        bit_end;

    assign bit_end = (baud_cnt_q == BIT_LAST);

    // Next-state logic: frame sequencing, baud counting, bit index and shifting.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                // Enable and empty are only looked at here.
                // A frame in flight always runs to its end.
                if (TX_En_Sig && !Empty_Sig) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The FIFO puts the popped byte on its read port during this cycle.
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shift_d    = FIFO_Read_Data;
                parity_d   = (^FIFO_Read_Data) ^ PARITY_ODD;
                baud_cnt_d = '0;
                state_d    = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // LSB first: shift right so the next data bit sits in bit 0.
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs track state_q.
    always_comb begin
        tx_d   = 1'b1;
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    // Reset is asynchronous and drops any byte that is partly sent.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
        end
    end

    assign Read_Req_Sig = req_q;
    assign TX_Pin_Out   = tx_q;
    assign TX_Busy_Sig  = busy_q;

endmodule

// File: tb/tb_fifo_tx_drain_module.sv
// tb_fifo_tx_drain_module
// Drives three instances of the drain module: no parity, even parity and odd parity.
// Each instance is fed from its own FIFO model.
// Every frame is checked against a waveform built directly from the UART framing rules.
`timescale 1ns/1ps
module tb_fifo_tx_drain_module;

    localparam int B = 4;   // clock cycles per bit
    localparam int N = 3;   // instance 0: 8N1, 1: 8E1, 2: 8O1

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] tx_en;
    logic [N-1:0] empty;
    logic [N-1:0] req;
    logic [N-1:0] pin;
    logic [N-1:0] busy;
    logic [7:0]   rd_data [N];

    // FIFO models: storage and write pointer belong to the stimulus.
    // The read side belongs to the pop process below.
    logic [7:0]   mem [N][16];
    int           wr_ptr [N] = '{default: 0};
    int           rd_ptr [N] = '{default: 0};
    int           pops   [N] = '{default: 0};

    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            fifo_tx_drain_module #(
                .BPS_CNT    (B),
                .PARITY_EN  ((gi > 0) ? 1'b1 : 1'b0),
                .PARITY_ODD ((gi == 2) ? 1'b1 : 1'b0)
            ) u_dut (
                .CLK            (clk),
                .RSTn           (rst_n),
                .TX_En_Sig      (tx_en[gi]),
                .Empty_Sig      (empty[gi]),
                .FIFO_Read_Data (rd_data[gi]),
                .Read_Req_Sig   (req[gi]),
                .TX_Pin_Out     (pin[gi]),
                .TX_Busy_Sig    (busy[gi])
            );
        end
    endgenerate

    // FIFO read side: data appears the cycle after a pop request.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                rd_data[k] <= mem[k][rd_ptr[k] % 16];
                rd_ptr[k]  <= rd_ptr[k] + 1;
                pops[k]    <= pops[k] + 1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int k = 0; k < N; k++) begin
            empty[k] = (wr_ptr[k] == rd_ptr[k]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wr_ptr[k] % 16] = b;
        wr_ptr[k] = wr_ptr[k] + 1;
    endtask

    // Expected pin level c cycles after the pop request (c = 0 is the request cycle).
    // The sequence is three set-up cycles, start bit, D0..D7, optional parity,
    // stop bit, then line idle.
    function automatic logic exp_pin(input logic [7:0] b, input int pe, input int odd, input int c);
        int bit_n;
        if (c < 3) return 1'b1;
        bit_n = (c - 3) / B;
        if (bit_n == 0) return 1'b0;
        if (bit_n <= 8) return b[bit_n - 1];
        if (pe != 0 && bit_n == 9) return (($countones(b) + odd) % 2) != 0;
        return 1'b1;
    endfunction

    task automatic wait_req(input int k, input int budget);
        int n;
        n = 0;
        while (req[k] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("req_within_budget", {31'd0, req[k]}, 32'd1);
    endtask

    // Follows one full frame of instance k, starting at its pop request.
    // If drop_at >= 0, enable is cleared that many cycles into the frame.
    task automatic expect_frame(input int k, input logic [7:0] b, input int drop_at);
        int         pe, odd, len, pin_bad, busy_bad, req_cnt, pops_before;
        logic [7:0] dec;
        logic       par_obs;
        pe       = (k > 0) ? 1 : 0;
        odd      = (k == 2) ? 1 : 0;
        len      = 3 + (10 + pe) * B;
        pin_bad  = 0;
        busy_bad = 0;
        req_cnt  = 0;
        dec      = '0;
        par_obs  = 1'bx;
        wait_req(k, 200);
        pops_before = pops[k];
        for (int c = 0; c <= len; c++) begin
            if (c == drop_at) tx_en[k] = 1'b0;
            if (pin[k] !== exp_pin(b, pe, odd, c)) pin_bad++;
            if (busy[k] !== ((c < len) ? 1'b1 : 1'b0)) busy_bad++;
            if (req[k] === 1'b1) req_cnt++;
            if (c >= 3 + B && c < 3 + 9 * B && ((c - 3) % B) == B / 2)
                dec[(c - 3) / B - 1] = pin[k];
            if (c == 3 + 9 * B + B / 2) par_obs = pin[k];
            if (c < len) @(negedge clk);
        end
        $display("frame inst=%0d byte=%02h decoded=%02h pin_err=%0d busy_err=%0d reqs=%0d",
                 k, b, dec, pin_bad, busy_bad, req_cnt);
        check("pin_waveform", pin_bad, 0);
        check("busy_length", busy_bad, 0);
        check("one_req_per_frame", req_cnt, 1);
        check("decoded_byte", dec, b);
        check("one_pop_per_frame", pops[k] - pops_before, 1);
        if (pe != 0)
            check("parity_bit", par_obs, (($countones(b) + odd) % 2));
    endtask

    initial begin
        logic [7:0] seq [5];
        int         bad;
        int         p0;

        rst_n = 1'b0;
        tx_en = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("reset_pin", pin[k], 1);
            check("reset_busy", busy[k], 0);
            check("reset_req", req[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0x55 on the 8N1 instance.
        push(0, 8'h55);
        tx_en[0] = 1'b1;
        expect_frame(0, 8'h55, -1);
        repeat (20) @(negedge clk);
        check("no_pop_when_empty_1", pops[0], 1);

        // Back-to-back bytes 0xA3 and 0x0F.
        push(0, 8'hA3);
        push(0, 8'h0F);
        expect_frame(0, 8'hA3, -1);
        @(negedge clk);
        check("b2b_req_gap", req[0], 1);
        expect_frame(0, 8'h0F, -1);
        repeat (30) @(negedge clk);
        check("no_pop_when_empty_3", pops[0], 3);

        // Enable low with data waiting: nothing moves until enable rises.
        tx_en[0] = 1'b0;
        push(0, 8'h3C);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (req[0] !== 1'b0 || pin[0] !== 1'b1) bad++;
        end
        check("en_low_holds_idle", bad, 0);
        tx_en[0] = 1'b1;
        @(negedge clk);
        check("en_rise_req_next_cycle", req[0], 1);
        expect_frame(0, 8'h3C, -1);

        // Asynchronous reset during data bit 3 of 0x00; 0xC6 must follow as a full frame.
        push(0, 8'h00);
        push(0, 8'hC6);
        wait_req(0, 50);
        p0 = pops[0];
        repeat (3 + B * 4 + 1) @(negedge clk);
        check("pin_low_before_reset", pin[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pin", pin[0], 1);
        check("async_reset_busy", busy[0], 0);
        check("async_reset_req", req[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_no_extra_pop", pops[0] - p0, 1);
        expect_frame(0, 8'hC6, -1);

        // Enable cleared during the start bit: the frame completes, then no more pops.
        push(0, 8'h9A);
        push(0, 8'h11);
        expect_frame(0, 8'h9A, 4);
        p0 = pops[0];
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (req[0] === 1'b1) bad++;
        end
        check("no_req_after_en_drop", bad, 0);
        check("no_pop_after_en_drop", pops[0] - p0, 0);

        // Random byte streams on all three instances.
        // Instance 0 first drains the 0x11 it still holds.
        for (int k = 0; k < N; k++) begin
            p0 = pops[k];
            seq[0] = (k == 0) ? 8'h11 : 8'h07;
            for (int i = 1; i < 5; i++) seq[i] = 8'($urandom_range(0, 255));
            if (k != 0) push(k, seq[0]);
            for (int i = 1; i < 5; i++) push(k, seq[i]);
            tx_en[k] = 1'b1;
            for (int i = 0; i < 5; i++) begin
                expect_frame(k, seq[i], -1);
                if (i < 4) begin
                    @(negedge clk);
                    check("rand_b2b_req_gap", req[k], 1);
                end
            end
            repeat (20) @(negedge clk);
            check("rand_pop_count", pops[k] - p0, 5);
            tx_en[k] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
